alu_cmd_issuer: RTL and testbench
=================================

# alu_cmd_issuer

Sequential front end of the simple ALU. Accepts binary-coded operation requests over a valid/ready handshake, decodes each opcode into the 6-bit one-hot `command` word consumed by the ALU result muxes, holds the operands and command stable for the ALU's execution latency, then captures the result and returns it over a second valid/ready handshake. It is the producer of the one-hot command bus that the ALU datapath muxes select on.

## Interface
- `DATA_W`, 32: operand and result width.
- `OP_W`, 3: binary opcode width.
- `CMD_W`, 6: one-hot command width.
- `ALU_LAT`, 1: cycles the command and operands must be held before the ALU result is valid; legal range 1..15.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_op`  in  OP_W  binary opcode.
- `req_a`, `req_b`  in  DATA_W  operands.
- `command`  out  CMD_W  one-hot command to ALU muxes; all-zero when idle.
- `alu_a`, `alu_b`  out  DATA_W  registered operands to ALU.
- `alu_result`  in  DATA_W  ALU result.
- `alu_ovf`  in  1  ALU overflow flag.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_data`  out  DATA_W  captured result.
- `rsp_ovf`  out  1  captured overflow.
- `rsp_err`  out  1  illegal opcode flag.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: `req_ready`=1, `command`=0. On `req_valid && req_ready`, register `req_a`/`req_b` into `alu_a`/`alu_b`, decode `req_op` and register the result into `command`, load the latency counter with `ALU_LAT-1`, and go to EXEC.
- Decode: opcode k in 0..5 gives `command` = 1<<k, so bit 0 = add, 1 = sub, 2 = and, 3 = or, 4 = sll, 5 = sra. Opcodes 6 and 7 are illegal (see Configuration).
- EXEC: `command`, `alu_a` and `alu_b` are held constant. The counter decrements each cycle. On the cycle the counter is 0:
  - capture `alu_result` into `rsp_data` and `alu_ovf` into `rsp_ovf`;
  - clear `command` to 0;
  - go to RESP.
- RESP: `rsp_valid`=1, and `rsp_data`, `rsp_ovf` and `rsp_err` are held stable. On `rsp_valid && rsp_ready`, go to IDLE and clear `rsp_valid`.
- `req_ready` is 1 only in IDLE. A request presented in EXEC or RESP is not accepted and is not lost to the requester; it must stay valid.
- No arithmetic is performed here. Results pass through unmodified at `DATA_W` bits.

## Timing
- Reset values: state IDLE; `command`=0; `alu_a`/`alu_b`=0; `rsp_valid`, `rsp_data`, `rsp_ovf`, `rsp_err` all 0; counter 0. `req_ready`=1 once `rst_n` is high.
- Request accepted at edge T:
  - `command` is valid from T+1 through T+`ALU_LAT`;
  - `rsp_valid` rises at T+1+`ALU_LAT`.
- Response handshake at edge R: `rsp_valid`=0 and `req_ready`=1 from R+1.
- Minimum initiation interval is `ALU_LAT`+2 cycles.
- `rsp_ready` held low: RESP persists indefinitely with outputs frozen.
- `rst_n` asserted in any state: all outputs return to reset values immediately (asynchronously). The in-flight operation is discarded and no response is produced.
- `command` is always either all-zero or exactly one bit set.

## Configuration
- `ALU_CMD_ILLEGAL_TRAP_EN` defined:
  - opcodes 6 and 7 skip EXEC and go straight to RESP one cycle after acceptance;
  - `rsp_err`=1 and `rsp_data`=0;
  - `command` stays 0 for the whole transaction.
- Not defined:
  - opcodes 6 and 7 decode as opcode 0 (`command`=000001) and run normally;
  - `rsp_err` is tied to 0.

## Structure
- Package `alu_cmd_pkg` holds:
  - opcode constants `OP_ADD`..`OP_SRA` (0..5);
  - `CMD_W`;
  - the FSM state enum;
  - a one-hot command typedef.
- Sub-module `alu_op_decoder` is a combinational opcode-to-one-hot decoder with an illegal-opcode output. It is instantiated once; the issuer registers its output.

## Test plan
- Reset: with `rst_n` low, all outputs are 0. After release, `req_ready`=1 and `command`=000000.
- `ALU_LAT`=1, stub ALU subtracts, request op=1, a=5, b=3 at T: `command`=000010 at T+1; `rsp_valid`=1 with `rsp_data`=2 at T+2.
- Backpressure: hold `rsp_ready`=0 for 5 cycles while `req_valid` stays 1. `rsp_data` stays stable, `req_ready`=0, and the second request is accepted only on the cycle after the response handshake.
- Op=7 with the macro defined: `rsp_valid` at T+1 with `rsp_err`=1 and `rsp_data`=0, and `command` is never nonzero. Without the macro: `command`=000001 and `rsp_err`=0.
- `ALU_LAT`=3, stub adder, a=0x7FFFFFFF, b=1: `command`=000001 for 3 cycles; `rsp_data`=0x80000000 and `rsp_ovf`=1 at T+4.
- Drop `rst_n` mid-EXEC: outputs go to 0 immediately, no `rsp_valid` follows, and `req_ready`=1 after release.

Source files
------------

// File: rtl/alu_cmd_issuer_pkg.sv
// Shared types and constants for the ALU command issuer: opcodes, command
// width, FSM state encoding and the one-hot command type.
package alu_cmd_pkg;

    localparam int CMD_W = 6;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_SLL = 3'd4;
    localparam logic [2:0] OP_SRA = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef logic [CMD_W-1:0] cmd_t;

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Request, ALU and response signals of the command issuer in one bundle.
// slave = issuer side, master = requester/ALU/consumer side.
interface alu_cmd_issuer_if #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 3,
    parameter int CMD_W  = 6
);
    logic              req_valid;
    logic              req_ready;
    logic [OP_W-1:0]   req_op;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic [CMD_W-1:0]  command;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_result;
    logic              alu_ovf;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_ovf;
    logic              rsp_err;

    modport slave (
        input  req_valid, req_op, req_a, req_b, alu_result, alu_ovf, rsp_ready,
        output req_ready, command, alu_a, alu_b, rsp_valid, rsp_data, rsp_ovf, rsp_err
    );

    modport master (
        output req_valid, req_op, req_a, req_b, alu_result, alu_ovf, rsp_ready,
        input  req_ready, command, alu_a, alu_b, rsp_valid, rsp_data, rsp_ovf, rsp_err
    );
endinterface

// File: rtl/alu_cmd_issuer_op_decoder.sv
// Combinational opcode -> one-hot command decoder with illegal-opcode flag.
// ALU_CMD_ILLEGAL_TRAP_EN: opcodes 6/7 flag illegal with a zero command.
module alu_op_decoder
    import alu_cmd_pkg::*;
#(
    parameter int OP_W = 3
) (
    input  logic [OP_W-1:0] op_i,
    output cmd_t            cmd_o,
    output logic            illegal_o
);

    always_comb begin
        cmd_o     = '0;
        illegal_o = 1'b0;
        if (int'(op_i) <= int'(OP_SRA)) begin
            cmd_o = cmd_t'(1) << op_i;
        end else begin
`ifdef ALU_CMD_ILLEGAL_TRAP_EN
            illegal_o = 1'b1;
`else
            // Unused opcodes fall back to add so the ALU always sees a legal command.
            cmd_o = cmd_t'(1) << OP_ADD;
`endif
        end
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Sequential ALU front end: accepts an opcode request, drives a held one-hot
// command for ALU_LAT cycles, then returns the captured result.
// ALU_CMD_ILLEGAL_TRAP_EN: opcodes 6/7 answer at once with rsp_err=1.
module alu_cmd_issuer
    import alu_cmd_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int OP_W    = 3,
    parameter int CMD_W   = alu_cmd_pkg::CMD_W,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_cmd_issuer_if.slave  bus
);

    localparam int CNT_W = 4;

    state_e            state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              ovf_q, ovf_d;
    logic              err_q, err_d;

    cmd_t dec_cmd;
    logic dec_illegal;

    alu_op_decoder #(
        .OP_W (OP_W)
    ) u_dec (
        .op_i      (bus.req_op),
        .cmd_o     (dec_cmd),
        .illegal_o (dec_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    a_d   = bus.req_a;
                    b_d   = bus.req_b;
                    cnt_d = CNT_W'(ALU_LAT - 1);
                    err_d = dec_illegal;
                    if (dec_illegal) begin
                        cmd_d   = '0;
                        data_d  = '0;
                        ovf_d   = 1'b0;
                        state_d = ST_RESP;
                    end else begin
                        cmd_d   = dec_cmd;
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                if (cnt_q == '0) begin
                    data_d  = bus.alu_result;
                    ovf_d   = bus.alu_ovf;
                    cmd_d   = '0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Ready is masked by rst_n so it reads 0 for the whole reset window.
    assign bus.req_ready = rst_n && (state_q == ST_IDLE);
    assign bus.command   = cmd_q;
    assign bus.alu_a     = a_q;
    assign bus.alu_b     = b_q;
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_data  = data_q;
    assign bus.rsp_ovf   = ovf_q;
`ifdef ALU_CMD_ILLEGAL_TRAP_EN
    assign bus.rsp_err   = err_q;
`else
    assign bus.rsp_err   = 1'b0;
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer: two instances (ALU_LAT=1 and 3) in front
// of a behavioural stub ALU; honours ALU_CMD_ILLEGAL_TRAP_EN.
module tb_alu_cmd_issuer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    alu_cmd_issuer_if #(.DATA_W(32), .OP_W(3), .CMD_W(6)) i1 ();
    alu_cmd_issuer_if #(.DATA_W(32), .OP_W(3), .CMD_W(6)) i3 ();

    alu_cmd_issuer #(.DATA_W(32), .OP_W(3), .CMD_W(6), .ALU_LAT(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (i1)
    );

    alu_cmd_issuer #(.DATA_W(32), .OP_W(3), .CMD_W(6), .ALU_LAT(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (i3)
    );

    function automatic logic [32:0] alu_stub(input logic [5:0] cmd,
                                             input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        o;
        r = '0;
        o = 1'b0;
        case (cmd)
            6'b000001: begin r = a + b; o = (a[31] == b[31]) && (r[31] != a[31]); end
            6'b000010: begin r = a - b; o = (a[31] != b[31]) && (r[31] != a[31]); end
            6'b000100: r = a & b;
            6'b001000: r = a | b;
            6'b010000: r = a << b[4:0];
            6'b100000: r = $unsigned($signed(a) >>> b[4:0]);
            default:   r = '0;
        endcase
        return {o, r};
    endfunction

    always_comb {i1.alu_ovf, i1.alu_result} = alu_stub(i1.command, i1.alu_a, i1.alu_b);
    always_comb {i3.alu_ovf, i3.alu_result} = alu_stub(i3.command, i3.alu_a, i3.alu_b);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        i1.req_valid = 0; i1.req_op = 0; i1.req_a = 0; i1.req_b = 0; i1.rsp_ready = 0;
        i3.req_valid = 0; i3.req_op = 0; i3.req_a = 0; i3.req_b = 0; i3.rsp_ready = 0;

        // Reset held low
        tick(); tick();
        chk("rst_req_ready", 32'(i1.req_ready), 32'd0);
        chk("rst_command",   32'(i1.command),   32'd0);
        chk("rst_alu_a",     i1.alu_a,          32'd0);
        chk("rst_rsp_valid", 32'(i1.rsp_valid), 32'd0);
        chk("rst_rsp_data",  i1.rsp_data,       32'd0);
        chk("rst_rsp_flags", {30'd0, i1.rsp_ovf, i1.rsp_err}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", 32'(i1.req_ready), 32'd1);
        chk("post_rst_cmd",   32'(i1.command),   32'd0);

        // LAT=1 subtract 5-3, then a second request waits behind backpressure
        i1.req_valid = 1; i1.req_op = 3'd1; i1.req_a = 32'd5; i1.req_b = 32'd3;
        tick();
        chk("sub_cmd",        32'(i1.command),   32'b000010);
        chk("sub_alu_a",      i1.alu_a,          32'd5);
        chk("sub_ready_exec", 32'(i1.req_ready), 32'd0);
        chk("sub_no_rsp_yet", 32'(i1.rsp_valid), 32'd0);
        i1.req_op = 3'd3; i1.req_a = 32'h0000_00F0; i1.req_b = 32'h0000_000F;
        tick();
        chk("sub_rsp_valid", 32'(i1.rsp_valid), 32'd1);
        chk("sub_rsp_data",  i1.rsp_data,       32'd2);
        chk("sub_rsp_ovf",   32'(i1.rsp_ovf),   32'd0);
        chk("sub_cmd_clr",   32'(i1.command),   32'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_rsp_valid", 32'(i1.rsp_valid), 32'd1);
            chk("bp_rsp_data",  i1.rsp_data,       32'd2);
            chk("bp_req_ready", 32'(i1.req_ready), 32'd0);
        end
        i1.rsp_ready = 1;
        tick();
        i1.rsp_ready = 0;
        chk("hs_rsp_valid", 32'(i1.rsp_valid), 32'd0);
        chk("hs_req_ready", 32'(i1.req_ready), 32'd1);
        chk("hs_cmd_idle",  32'(i1.command),   32'd0);
        tick();
        i1.req_valid = 0;
        chk("or_cmd",   32'(i1.command), 32'b001000);
        chk("or_alu_a", i1.alu_a,        32'h0000_00F0);
        tick();
        chk("or_rsp_valid", 32'(i1.rsp_valid), 32'd1);
        chk("or_rsp_data",  i1.rsp_data,       32'h0000_00FF);
        i1.rsp_ready = 1;
        tick();
        i1.rsp_ready = 0;

        // Opcode 7
        i1.req_valid = 1; i1.req_op = 3'd7; i1.req_a = 32'd9; i1.req_b = 32'd4;
        tick();
        i1.req_valid = 0;
`ifdef ALU_CMD_ILLEGAL_TRAP_EN
        chk("ill_cmd",       32'(i1.command),   32'd0);
        chk("ill_rsp_valid", 32'(i1.rsp_valid), 32'd1);
        chk("ill_rsp_err",   32'(i1.rsp_err),   32'd1);
        chk("ill_rsp_data",  i1.rsp_data,       32'd0);
`else
        chk("op7_cmd",       32'(i1.command),   32'b000001);
        chk("op7_no_rsp",    32'(i1.rsp_valid), 32'd0);
        tick();
        chk("op7_rsp_valid", 32'(i1.rsp_valid), 32'd1);
        chk("op7_rsp_data",  i1.rsp_data,       32'd13);
        chk("op7_rsp_err",   32'(i1.rsp_err),   32'd0);
        chk("op7_cmd_clr",   32'(i1.command),   32'd0);
`endif
        i1.rsp_ready = 1;
        tick();
        i1.rsp_ready = 0;
        chk("op7_back_idle", 32'(i1.req_ready), 32'd1);

        // LAT=3 add with signed overflow
        i3.req_valid = 1; i3.req_op = 3'd0; i3.req_a = 32'h7FFF_FFFF; i3.req_b = 32'd1;
        tick();
        i3.req_valid = 0;
        for (int k = 0; k < 3; k++) begin
            chk("add3_cmd",    32'(i3.command),   32'b000001);
            chk("add3_no_rsp", 32'(i3.rsp_valid), 32'd0);
            if (k < 2) tick();
        end
        tick();
        chk("add3_rsp_valid", 32'(i3.rsp_valid), 32'd1);
        chk("add3_rsp_data",  i3.rsp_data,       32'h8000_0000);
        chk("add3_rsp_ovf",   32'(i3.rsp_ovf),   32'd1);
        chk("add3_cmd_clr",   32'(i3.command),   32'd0);
        i3.rsp_ready = 1;
        tick();
        i3.rsp_ready = 0;

        // Reset dropped mid-EXEC
        i3.req_valid = 1; i3.req_op = 3'd4; i3.req_a = 32'd1; i3.req_b = 32'd4;
        tick();
        i3.req_valid = 0;
        chk("sll_cmd", 32'(i3.command), 32'b010000);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cmd",       32'(i3.command),   32'd0);
        chk("arst_alu_a",     i3.alu_a,          32'd0);
        chk("arst_req_ready", 32'(i3.req_ready), 32'd0);
        chk("arst_rsp_data",  i3.rsp_data,       32'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("arst_no_rsp", 32'(i3.rsp_valid), 32'd0);
            chk("arst_ready",  32'(i3.req_ready), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
